intr_ctrl: RTL and testbench

Interrupt controller sitting directly downstream of the timer peripherals: it collects their `int_match`/`int_ovf` pulses, plus any other single-cycle or level interrupt sources, into one CPU interrupt request. It latches, masks and prioritises these sources, presents one vector to the core through an irq/ack handshake, and holds off further requests until software signals end-of-interrupt (EOI). Software programs it through the same 2-bit-address, always-ack register port used by the timers.

---
 rtl/intr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_intr_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: collects pulse/level interrupt sources, masks and prioritises
// them (lowest index wins), and presents a single request to the core through
// an irq/ack handshake. Further requests are held off until software writes
// the STATUS/EOI register.
module intr_ctrl #(
   parameter int NSRC  = 8,
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NSRC-1:0]  src,
   output logic             irq,
   output logic [VEC_W-1:0] irq_vec,
   input  logic             irq_ack,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      dtw,
   output logic [31:0]      dtr,
   input  logic             stb,
   output logic             ack
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state_r;
   logic [NSRC-1:0]    enable_r;
   logic [NSRC-1:0]    pending_r;
   logic [NSRC-1:0]    mode_r;
   logic               irq_r;
   logic [VEC_W-1:0]   irq_vec_r;
   logic               in_service_r;

   logic               wr_en_s;
   logic               eoi_s;
   logic [NSRC-1:0]    w1c_s;
   logic [NSRC-1:0]    ack_clr_s;
   logic [NSRC-1:0]    req_s;
   logic [NSRC-1:0]    pending_next_s;
   logic [VEC_W-1:0]   win_idx_s;
   logic [31:0]        dtr_s;
   logic               dtw_unused_s;

   // Lowest set index of a request vector; zero when nothing is set.
   function automatic logic [VEC_W-1:0] prio_enc(input logic [NSRC-1:0] v);
      logic [VEC_W-1:0] idx;
      idx = {VEC_W{1'b0}};
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = VEC_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign ack          = 1'b1;
   assign irq          = irq_r;
   assign irq_vec      = irq_vec_r;
   assign dtr          = dtr_s;
   assign dtw_unused_s = ^dtw;

   // Decode bus writes, ack-driven clears and the next pending vector.
   always_comb begin
      wr_en_s   = we & stb;
      eoi_s     = wr_en_s && (addr == 2'd3);
      w1c_s     = {NSRC{1'b0}};
      ack_clr_s = {NSRC{1'b0}};
      if (wr_en_s && (addr == 2'd1)) begin
         w1c_s = dtw[NSRC-1:0];
      end else begin
         w1c_s = {NSRC{1'b0}};
      end
      if ((state_r == ST_REQ) && irq_ack) begin
         ack_clr_s = {{(NSRC-1){1'b0}}, 1'b1} << irq_vec_r;
      end else begin
         ack_clr_s = {NSRC{1'b0}};
      end
      // Level bits reduce to the registered source; edge bits are sticky and
      // a same-cycle source pulse beats any clear.
      pending_next_s = src | (pending_r & mode_r & ~w1c_s & ~ack_clr_s);
      req_s          = pending_r & enable_r;
      win_idx_s      = prio_enc(req_s);
   end

   // Register read mux; upper bits beyond the source count read zero.
   always_comb begin
      dtr_s = 32'd0;
      case (addr)
         2'd0: dtr_s[NSRC-1:0] = enable_r;
         2'd1: dtr_s[NSRC-1:0] = pending_r;
         2'd2: dtr_s[NSRC-1:0] = mode_r;
         2'd3: begin
            dtr_s[9]         = in_service_r;
            dtr_s[8]         = irq_r;
            dtr_s[VEC_W-1:0] = irq_vec_r;
         end
         default: dtr_s = 32'd0;
      endcase
   end

   // Configuration registers, pending latch and the request/service FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         enable_r     <= {NSRC{1'b0}};
         pending_r    <= {NSRC{1'b0}};
         mode_r       <= {NSRC{1'b0}};
         irq_r        <= 1'b0;
         irq_vec_r    <= {VEC_W{1'b0}};
         in_service_r <= 1'b0;
      end else begin
         if (wr_en_s && (addr == 2'd0)) begin
            enable_r <= dtw[NSRC-1:0];
         end
         if (wr_en_s && (addr == 2'd2)) begin
            mode_r <= dtw[NSRC-1:0];
         end
         pending_r <= pending_next_s;

         case (state_r)
            ST_IDLE: begin
               in_service_r <= 1'b0;
               if (req_s != {NSRC{1'b0}}) begin
                  state_r   <= ST_REQ;
                  irq_r     <= 1'b1;
                  irq_vec_r <= win_idx_s;
               end else begin
                  irq_r <= 1'b0;
               end
            end
            ST_REQ: begin
               // Ack wins over a same-cycle withdraw; no re-vectoring here.
               if (irq_ack) begin
                  state_r      <= ST_SERVICE;
                  irq_r        <= 1'b0;
                  in_service_r <= 1'b1;
               end else if (!req_s[irq_vec_r]) begin
                  state_r   <= ST_IDLE;
                  irq_r     <= 1'b0;
                  irq_vec_r <= {VEC_W{1'b0}};
               end else begin
                  irq_r <= 1'b1;
               end
            end
            ST_SERVICE: begin
               irq_r <= 1'b0;
               if (eoi_s) begin
                  state_r      <= ST_IDLE;
                  in_service_r <= 1'b0;
                  irq_vec_r    <= {VEC_W{1'b0}};
               end else begin
                  in_service_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               irq_r        <= 1'b0;
               irq_vec_r    <= {VEC_W{1'b0}};
               in_service_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: register table vectors plus hand-written
// handshake sequences, with expected values queued at stimulus time.
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  src;
   logic        irq;
   logic [2:0]  irq_vec;
   logic        irq_ack;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] dtw;
   logic [31:0] dtr;
   logic        stb;
   logic        ack;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic [1:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[7];

   intr_ctrl #(.NSRC(8), .VEC_W(3)) dut (
      .clk(clk), .reset(reset), .src(src), .irq(irq), .irq_vec(irq_vec),
      .irq_ack(irq_ack), .we(we), .addr(addr), .dtw(dtw), .dtr(dtr),
      .stb(stb), .ack(ack)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] exp);
      sb_q.push_back(exp);
   endtask

   task automatic pop_chk(input string name, input logic [31:0] act);
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty actual=0x%0h", name, act);
      end else begin
         chk(name, act, sb_q.pop_front());
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; stb = 1'b1; addr = a; dtw = d;
      tick();
      we = 1'b0; stb = 1'b0; dtw = 32'd0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a);
      addr = a;
      #1;
      pop_chk(name, dtr);
   endtask

   task automatic irq_chk(input string name, input logic exp_irq, input logic [2:0] exp_vec);
      chk({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
      chk({name, "_vec"}, {29'd0, irq_vec}, {29'd0, exp_vec});
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; src = 8'd0; irq_ack = 1'b0; we = 1'b0; stb = 1'b0;
      addr = 2'd0; dtw = 32'd0;
      tick(); tick();
      reset = 1'b0;

      // Reset state.
      irq_chk("reset", 1'b0, 3'd0);
      chk("ack_tied", {31'd0, ack}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         push(32'd0);
         rd_chk("reset_reg", 2'(i));
      end

      // Register table: writes land next cycle, upper bits read zero.
      tbl[0] = '{2'd0, 32'hFFFF_FF5A, 32'h0000_005A};
      tbl[1] = '{2'd2, 32'h1234_56A5, 32'h0000_00A5};
      tbl[2] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[3] = '{2'd3, 32'h0000_0000, 32'h0000_0000};
      tbl[4] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
      tbl[5] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
      tbl[6] = '{2'd2, 32'h0000_0100, 32'h0000_0000};
      for (int i = 0; i < 7; i++) begin
         push(tbl[i].exp);
         wr(tbl[i].a, tbl[i].wd);
         rd_chk("tbl_reg", tbl[i].a);
      end
      // Stray ack in IDLE is ignored.
      pulse_ack();
      push(32'd0);
      rd_chk("ack_idle", 2'd3);

      // Test 1: single edge source, two-cycle latency, ack, EOI.
      wr(2'd0, 32'h02); wr(2'd2, 32'h02);
      src = 8'h02; push(32'h02);
      tick();
      src = 8'h00;
      rd_chk("t1_pend", 2'd1);
      chk("t1_irq_early", {31'd0, irq}, 32'd0);
      tick();
      irq_chk("t1_req", 1'b1, 3'd1);
      pulse_ack();
      chk("t1_irq_drop", {31'd0, irq}, 32'd0);
      push(32'h00); rd_chk("t1_pend_clr", 2'd1);
      push(32'h201); rd_chk("t1_status", 2'd3);
      wr(2'd3, 32'd0);
      push(32'h000); rd_chk("t1_eoi", 2'd3);

      // Test 2: simultaneous sources resolve lowest first.
      wr(2'd0, 32'hFF); wr(2'd2, 32'hFF);
      src = 8'h24;
      tick();
      src = 8'h00;
      tick();
      irq_chk("t2_first", 1'b1, 3'd2);
      pulse_ack();
      wr(2'd3, 32'd0);
      chk("t2_after_eoi", {31'd0, irq}, 32'd0);
      tick();
      irq_chk("t2_second", 1'b1, 3'd5);
      pulse_ack();
      wr(2'd3, 32'd0);
      tick();
      chk("t2_quiet", {31'd0, irq}, 32'd0);

      // Test 3: masking while in REQ withdraws the request.
      src = 8'h08;
      tick();
      src = 8'h00;
      tick();
      irq_chk("t3_req", 1'b1, 3'd3);
      wr(2'd0, 32'h00);
      chk("t3_hold", {31'd0, irq}, 32'd1);
      tick();
      chk("t3_withdraw", {31'd0, irq}, 32'd0);
      push(32'h000); rd_chk("t3_status", 2'd3);
      push(32'h08); rd_chk("t3_pend", 2'd1);
      wr(2'd1, 32'h08);
      push(32'h00); rd_chk("t3_w1c", 2'd1);

      // Test 4: set beats W1C and set beats ack clear.
      src = 8'h01; we = 1'b1; stb = 1'b1; addr = 2'd1; dtw = 32'h01;
      tick();
      src = 8'h00; we = 1'b0; stb = 1'b0; dtw = 32'd0;
      push(32'h01); rd_chk("t4_set_w1c", 2'd1);
      wr(2'd0, 32'h01);
      tick();
      irq_chk("t4_req", 1'b1, 3'd0);
      src = 8'h01; irq_ack = 1'b1;
      tick();
      src = 8'h00; irq_ack = 1'b0;
      chk("t4_irq_drop", {31'd0, irq}, 32'd0);
      push(32'h01); rd_chk("t4_set_ack", 2'd1);
      push(32'h200); rd_chk("t4_status", 2'd3);
      wr(2'd3, 32'd0);
      tick();
      irq_chk("t4_reassert", 1'b1, 3'd0);
      pulse_ack();
      wr(2'd3, 32'd0);
      tick();
      chk("t4_quiet", {31'd0, irq}, 32'd0);

      // Test 5: level source re-asserts after EOI and withdraws on drop.
      wr(2'd2, 32'hEF); wr(2'd0, 32'h10);
      src = 8'h10;
      tick(); tick();
      irq_chk("t5_req", 1'b1, 3'd4);
      pulse_ack();
      push(32'h204); rd_chk("t5_status", 2'd3);
      wr(2'd1, 32'h10);
      wr(2'd3, 32'd0);
      chk("t5_eoi_p1", {31'd0, irq}, 32'd0);
      tick();
      irq_chk("t5_reassert", 1'b1, 3'd4);
      src = 8'h00;
      tick();
      tick();
      chk("t5_withdraw", {31'd0, irq}, 32'd0);
      push(32'h00); rd_chk("t5_pend", 2'd1);

      // Test 6: reset during SERVICE with pending bits set.
      wr(2'd2, 32'hFF); wr(2'd0, 32'hFF);
      src = 8'h81;
      tick();
      src = 8'h00;
      tick();
      irq_chk("t6_req", 1'b1, 3'd0);
      pulse_ack();
      src = 8'h01;
      tick();
      src = 8'h00;
      push(32'h81); rd_chk("t6_pend", 2'd1);
      push(32'h200); rd_chk("t6_status", 2'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      irq_chk("t6_after_rst", 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         push(32'd0);
         rd_chk("t6_reg", 2'(i));
      end
      tick(); tick();
      chk("t6_no_irq", {31'd0, irq}, 32'd0);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
